writeback_stage: RTL and testbench

//  Final pipeline stage; consumes the control bundle produced by decode (wA, MregWB, Mr7WB, IR) after EX/MEM.

---
 rtl/lca_pkg.sv | 45 ++++
 rtl/mux16x4.sv | 20 ++
 rtl/writeback_stage.sv | 166 ++++++++++++++++
 tb/tb_writeback_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lca_pkg.sv
// Shared ISA constants and opcode classification helpers for the pipeline control path.
package lca_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    localparam logic [1:0] COND_Z = 2'b01;
    localparam logic [1:0] COND_C = 2'b10;

    localparam logic [2:0] MREG_MEM = 3'd0;
    localparam logic [2:0] MREG_ALU = 3'd1;
    localparam logic [2:0] MREG_IMM = 3'd2;
    localparam logic [2:0] MREG_PC1 = 3'd3;

    localparam logic [3:0] MR7_NONE   = 4'd0;
    localparam logic [3:0] MR7_MEM    = 4'd1;
    localparam logic [3:0] MR7_PCIMM  = 4'd2;
    localparam logic [3:0] MR7_ALU    = 4'd3;
    localparam logic [3:0] MR7_RFOUT2 = 4'd4;

    function automatic logic is_rf_writer(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADI, OP_NDU, OP_LHI, OP_LW, OP_LM, OP_JAL, OP_JLR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic updates_c(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADI);
    endfunction

    function automatic logic updates_z(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADI) || (op == OP_NDU) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/mux16x4.sv
// Four-way data selector used for the register-file write-data source.
module mux16x4 #(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: registers one instruction, applies conditional execution, owns C/Z,
// drives the RF write port and PC redirect, and counts retired instructions.
module writeback_stage import lca_pkg::*; #(
    parameter int WIDTH  = 16,
    parameter int SHADOW = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [15:0]      in_ir,
    input  logic [2:0]       in_wA,
    input  logic [2:0]       in_MregWB,
    input  logic [3:0]       in_Mr7WB,
    input  logic [WIDTH-1:0] in_alu_out,
    input  logic             in_alu_c,
    input  logic             in_alu_z,
    input  logic [WIDTH-1:0] in_mem_data,
    input  logic [WIDTH-1:0] in_imm970,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_pc_imm,
    input  logic [WIDTH-1:0] in_rfout2,
    input  logic             in_beq_taken,
    output logic             rf_we,
    output logic [2:0]       rf_wa,
    output logic [WIDTH-1:0] rf_wd,
    output logic             redirect,
    output logic [WIDTH-1:0] pc_target,
    output logic             flag_c,
    output logic             flag_z,
    output logic [CNT_W-1:0] retire_count
);
    localparam int SH_W = $clog2(SHADOW + 2);

    logic             wb_valid_q;
    logic [3:0]       wb_op_q;
    logic [1:0]       wb_cond_q;
    logic [2:0]       wb_wa_q;
    logic [2:0]       wb_mreg_q;
    logic [3:0]       wb_mr7_q;
    logic [WIDTH-1:0] wb_alu_q, wb_mem_q, wb_imm_q, wb_pc_q, wb_pc_imm_q, wb_rfout2_q;
    logic             wb_alu_c_q, wb_alu_z_q, wb_beq_q;
    logic             flag_c_q, flag_z_q, flag_c_d, flag_z_d;
    logic [SH_W-1:0]  shadow_q, shadow_d, shadow_eff;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic             cond_ok, exec, squash, redir_src;
    logic [WIDTH-1:0] pc_plus1, mux_wd, redir_tgt;
    logic             unused_ir_bits;

    assign unused_ir_bits = ^in_ir[11:2];

    // Predicated ADC/ADZ/NDC/NDZ only fail when the referenced flag is clear.
    always_comb begin
        cond_ok = 1'b1;
        if ((wb_op_q == OP_ADD) || (wb_op_q == OP_NDU)) begin
            if ((wb_cond_q == COND_C && !flag_c_q) || (wb_cond_q == COND_Z && !flag_z_q))
                cond_ok = 1'b0;
        end
    end

    // Reset suppresses the held instruction's effects in the same cycle.
    assign exec     = wb_valid_q & cond_ok & ~reset;
    assign pc_plus1 = wb_pc_q + WIDTH'(1);

    mux16x4 #(.WIDTH(WIDTH)) u_wd_mux (
        .sel (wb_mreg_q[1:0]),
        .d0  (wb_mem_q),
        .d1  (wb_alu_q),
        .d2  (wb_imm_q),
        .d3  (pc_plus1),
        .y   (mux_wd)
    );

    assign rf_we = exec & is_rf_writer(wb_op_q);
    assign rf_wa = wb_wa_q;
    assign rf_wd = wb_mreg_q[2] ? '0 : mux_wd;

    always_comb begin
        redir_src = 1'b0;
        redir_tgt = '0;
        case (wb_mr7_q)
            MR7_MEM:    begin redir_src = 1'b1; redir_tgt = wb_mem_q;    end
            MR7_PCIMM:  begin redir_src = 1'b1; redir_tgt = wb_pc_imm_q; end
            MR7_ALU:    begin redir_src = 1'b1; redir_tgt = wb_alu_q;    end
            MR7_RFOUT2: begin redir_src = 1'b1; redir_tgt = wb_rfout2_q; end
            MR7_NONE: begin
                if (rf_we && wb_wa_q == 3'd7) begin
                    redir_src = 1'b1;
                    redir_tgt = rf_wd;
                end
            end
            default: ;
        endcase
        if (wb_op_q == OP_BEQ && !wb_beq_q)
            redir_src = 1'b0;
    end

    assign redirect  = exec & redir_src;
    assign pc_target = redirect ? redir_tgt : '0;

    // A redirect counts as the first shadow cycle, so the capture at its own edge is squashed.
    assign shadow_eff = redirect ? SH_W'(SHADOW) : shadow_q;
    assign squash     = (shadow_eff != '0);
    assign shadow_d   = squash ? shadow_eff - SH_W'(1) : '0;

    always_comb begin
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        if (exec && updates_c(wb_op_q))
            flag_c_d = wb_alu_c_q;
        if (exec && updates_z(wb_op_q))
            flag_z_d = (wb_op_q == OP_LW) ? (wb_mem_q == '0) : wb_alu_z_q;
    end

    assign retire_d = retire_q + CNT_W'(wb_valid_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q  <= 1'b0;
            wb_op_q     <= '0;
            wb_cond_q   <= '0;
            wb_wa_q     <= '0;
            wb_mreg_q   <= '0;
            wb_mr7_q    <= '0;
            wb_alu_q    <= '0;
            wb_mem_q    <= '0;
            wb_imm_q    <= '0;
            wb_pc_q     <= '0;
            wb_pc_imm_q <= '0;
            wb_rfout2_q <= '0;
            wb_alu_c_q  <= 1'b0;
            wb_alu_z_q  <= 1'b0;
            wb_beq_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            shadow_q    <= '0;
            retire_q    <= '0;
        end else begin
            wb_valid_q  <= in_valid & ~squash;
            wb_op_q     <= in_ir[15:12];
            wb_cond_q   <= in_ir[1:0];
            wb_wa_q     <= in_wA;
            wb_mreg_q   <= in_MregWB;
            wb_mr7_q    <= in_Mr7WB;
            wb_alu_q    <= in_alu_out;
            wb_mem_q    <= in_mem_data;
            wb_imm_q    <= in_imm970;
            wb_pc_q     <= in_pc;
            wb_pc_imm_q <= in_pc_imm;
            wb_rfout2_q <= in_rfout2;
            wb_alu_c_q  <= in_alu_c;
            wb_alu_z_q  <= in_alu_z;
            wb_beq_q    <= in_beq_taken;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            shadow_q    <= shadow_d;
            retire_q    <= retire_d;
        end
    end

    assign flag_c       = flag_c_q;
    assign flag_z       = flag_z_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected effects queued at issue, popped in the effect cycle.
module tb_writeback_stage;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [15:0]      in_ir;
    logic [2:0]       in_wA;
    logic [2:0]       in_MregWB;
    logic [3:0]       in_Mr7WB;
    logic [WIDTH-1:0] in_alu_out;
    logic             in_alu_c;
    logic             in_alu_z;
    logic [WIDTH-1:0] in_mem_data;
    logic [WIDTH-1:0] in_imm970;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_pc_imm;
    logic [WIDTH-1:0] in_rfout2;
    logic             in_beq_taken;
    logic             rf_we;
    logic [2:0]       rf_wa;
    logic [WIDTH-1:0] rf_wd;
    logic             redirect;
    logic [WIDTH-1:0] pc_target;
    logic             flag_c;
    logic             flag_z;
    logic [CNT_W-1:0] retire_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        rd;
        logic [15:0] tg;
    } exp_t;
    exp_t exp_q[$];

    writeback_stage #(.WIDTH(WIDTH), .SHADOW(1), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ir        (in_ir),
        .in_wA        (in_wA),
        .in_MregWB    (in_MregWB),
        .in_Mr7WB     (in_Mr7WB),
        .in_alu_out   (in_alu_out),
        .in_alu_c     (in_alu_c),
        .in_alu_z     (in_alu_z),
        .in_mem_data  (in_mem_data),
        .in_imm970    (in_imm970),
        .in_pc        (in_pc),
        .in_pc_imm    (in_pc_imm),
        .in_rfout2    (in_rfout2),
        .in_beq_taken (in_beq_taken),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .redirect     (redirect),
        .pc_target    (pc_target),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [15:0] ir, input logic [2:0] wa,
                         input logic [2:0] mreg, input logic [3:0] mr7);
        in_ir = ir; in_wA = wa; in_MregWB = mreg; in_Mr7WB = mr7;
        in_alu_out = '0; in_alu_c = 1'b0; in_alu_z = 1'b0; in_mem_data = '0;
        in_imm970 = '0; in_pc = '0; in_pc_imm = '0; in_rfout2 = '0; in_beq_taken = 1'b0;
    endtask

    // Queue expectation, capture the driven instruction, then compare its effect cycle.
    task automatic go(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      input logic rd, input logic [15:0] tg);
        exp_t e;
        e.we = we; e.wa = wa; e.wd = wd; e.rd = rd; e.tg = tg;
        exp_q.push_back(e);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            $display("txn ir=%h we=%0b wa=%0d wd=%h redirect=%0b target=%h",
                     in_ir, rf_we, rf_wa, rf_wd, redirect, pc_target);
            check("rf_we", 32'(rf_we), 32'(e.we));
            check("redirect", 32'(redirect), 32'(e.rd));
            if (e.we) begin
                check("rf_wa", 32'(rf_wa), 32'(e.wa));
                check("rf_wd", 32'(rf_wd), 32'(e.wd));
            end
            if (e.rd)
                check("pc_target", 32'(pc_target), 32'(e.tg));
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic c, input logic z, input logic [CNT_W-1:0] cnt);
        check({tag, "_flag_c"}, 32'(flag_c), 32'(c));
        check({tag, "_flag_z"}, 32'(flag_z), 32'(z));
        check({tag, "_count"}, 32'(retire_count), 32'(cnt));
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        drive(16'h0000, 3'd0, 3'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_rf_wa", 32'(rf_wa), 32'd0);
        check("rst_rf_wd", 32'(rf_wd), 32'd0);
        check("rst_pc_target", 32'(pc_target), 32'd0);
        check_state("rst", 1'b0, 1'b0, 4'd0);
        reset = 1'b0;

        // ADD R3 = R1 + R2
        drive(16'h0298, 3'd3, 3'd1, 4'd0); in_alu_out = 16'h0005; in_alu_c = 1'b1;
        go(1'b1, 3'd3, 16'h0005, 1'b0, 16'h0);
        idle();
        check_state("add", 1'b1, 1'b0, 4'd1);

        // Clear C, then ADC must be skipped but still retire
        drive(16'h0298, 3'd3, 3'd1, 4'd0); in_alu_out = 16'h0007;
        go(1'b1, 3'd3, 16'h0007, 1'b0, 16'h0);
        drive(16'h029A, 3'd3, 3'd1, 4'd0); in_alu_out = 16'h0009; in_alu_c = 1'b1; in_alu_z = 1'b1;
        go(1'b0, 3'd3, 16'h0009, 1'b0, 16'h0);
        idle();
        check_state("adc_skip", 1'b0, 1'b0, 4'd3);

        // Set C, then ADC executes
        drive(16'h0298, 3'd3, 3'd1, 4'd0); in_alu_out = 16'h0002; in_alu_c = 1'b1;
        go(1'b1, 3'd3, 16'h0002, 1'b0, 16'h0);
        drive(16'h029A, 3'd3, 3'd1, 4'd0); in_alu_out = 16'h000A; in_alu_z = 1'b1;
        go(1'b1, 3'd3, 16'h000A, 1'b0, 16'h0);
        idle();
        check_state("adc_exec", 1'b0, 1'b1, 4'd5);

        // ADZ with Z=1 executes; NDZ with Z=0 is skipped
        drive(16'h0299, 3'd3, 3'd1, 4'd0); in_alu_out = 16'h0003; in_alu_c = 1'b1;
        go(1'b1, 3'd3, 16'h0003, 1'b0, 16'h0);
        drive(16'h2299, 3'd3, 3'd1, 4'd0); in_alu_out = 16'h0004; in_alu_z = 1'b1;
        go(1'b0, 3'd3, 16'h0004, 1'b0, 16'h0);
        idle();
        check_state("adz_ndz", 1'b1, 1'b0, 4'd7);

        // BEQ taken: redirect, and the instruction arriving in the redirect cycle is squashed
        drive(16'hC000, 3'd0, 3'd0, 4'd2); in_pc_imm = 16'h0040; in_beq_taken = 1'b1;
        go(1'b0, 3'd0, 16'h0, 1'b1, 16'h0040);
        drive(16'h0298, 3'd4, 3'd1, 4'd0); in_alu_out = 16'h1234; in_alu_z = 1'b1;
        go(1'b0, 3'd4, 16'h1234, 1'b0, 16'h0);
        idle();
        check_state("beq_squash", 1'b1, 1'b0, 4'd8);

        drive(16'h0298, 3'd4, 3'd1, 4'd0); in_alu_out = 16'h0011;
        go(1'b1, 3'd4, 16'h0011, 1'b0, 16'h0);
        drive(16'hC000, 3'd0, 3'd0, 4'd2); in_pc_imm = 16'h0040; in_beq_taken = 1'b0;
        go(1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        drive(16'h0298, 3'd4, 3'd1, 4'd0); in_alu_out = 16'h0022;
        go(1'b1, 3'd4, 16'h0022, 1'b0, 16'h0);
        idle();
        check_state("beq_nt", 1'b0, 1'b0, 4'd11);

        // JAL R5 links pc+1 and jumps; JLR jumps to RB
        drive(16'h8A00, 3'd5, 3'd3, 4'd2); in_pc = 16'h0010; in_pc_imm = 16'h0030;
        go(1'b1, 3'd5, 16'h0011, 1'b1, 16'h0030);
        drive(16'h0298, 3'd1, 3'd1, 4'd0); in_alu_out = 16'h0055;
        go(1'b0, 3'd1, 16'h0055, 1'b0, 16'h0);
        drive(16'h9000, 3'd6, 3'd3, 4'd4); in_pc = 16'h0020; in_rfout2 = 16'h0100;
        go(1'b1, 3'd6, 16'h0021, 1'b1, 16'h0100);
        idle();
        check_state("jal_jlr", 1'b0, 1'b0, 4'd13);

        // LHI to R7 redirects to the written value; LW of zero sets Z
        drive(16'h3E00, 3'd7, 3'd2, 4'd0); in_imm970 = 16'hFF80;
        go(1'b1, 3'd7, 16'hFF80, 1'b1, 16'hFF80);
        idle();
        drive(16'h4400, 3'd2, 3'd0, 4'd0); in_mem_data = 16'h0000; in_alu_out = 16'h0BAD;
        go(1'b1, 3'd2, 16'h0000, 1'b0, 16'h0);
        idle();
        check_state("lhi_lw", 1'b0, 1'b1, 4'd15);

        // Reset while an ADD is held: no write, state cleared
        drive(16'h0298, 3'd3, 3'd1, 4'd0); in_alu_out = 16'h0077; in_alu_c = 1'b1; in_alu_z = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_rf_we", 32'(rf_we), 32'd0);
        check("midrst_redirect", 32'(redirect), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_state("midrst", 1'b0, 1'b0, 4'd0);

        // Back-to-back retirements wrap the counter
        for (int i = 1; i <= 15; i++) begin
            drive(16'h0298, 3'd1, 3'd1, 4'd0); in_alu_out = 16'(i);
            go(1'b1, 3'd1, 16'(i), 1'b0, 16'h0);
        end
        idle();
        check("wrap_pre_count", 32'(retire_count), 32'd15);
        drive(16'h0298, 3'd1, 3'd1, 4'd0); in_alu_out = 16'h0010;
        go(1'b1, 3'd1, 16'h0010, 1'b0, 16'h0);
        idle();
        check("wrap_count", 32'(retire_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
